// File: rtl/adc_capture_ctl_if.sv
// ---------------------------------------------------------------------------
// adc_capture_ctl_if
//   Capture RAM write port between adc_capture_ctl and the capture RAM.
//
//   Parameters
//     AW : RAM address width (depth is 2^AW words)
//     WW : RAM word width (all channels packed side by side)
//
//   Signals
//     mem_we    : one-cycle write enable
//     mem_addr  : write address
//     mem_wdata : write data, channel k in bits [(k+1)*DW-1 -: DW]
//
//   Modports
//     master : controller side, drives the write port
//     slave  : RAM side, receives the write port
// ---------------------------------------------------------------------------
interface adc_capture_ctl_if #(
    parameter int AW = 14,
    parameter int WW = 128
);
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [WW-1:0] mem_wdata;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        input mem_we,
        input mem_addr,
        input mem_wdata
    );
endinterface

// File: rtl/adc_capture_ctl.sv
// ---------------------------------------------------------------------------
// adc_capture_ctl
//   Multi-channel triggered capture controller for the digitizer ADC path.
//   Keeps 1 of every decim+1 valid samples, fills a pre-trigger window,
//   then writes circularly until a trigger (software or ext_trig rising
//   edge) is accepted, then fills the post-trigger window so the RAM holds
//   exactly 2^AW samples ending just before start_addr wraps round.
//
//   Parameters
//     NCH : number of ADC channels
//     DW  : bits per channel sample
//     AW  : capture depth is 2^AW samples per channel
//     CW  : decimation counter width
//
//   Ports
//     clk, rst_n    : ADC-domain clock, asynchronous active-low reset
//     adc_data      : packed channel samples, channel k at [(k+1)*DW-1 -: DW]
//     adc_valid     : adc_data qualifier
//     chan_mask     : 1 = channel stored, 0 = stored as zero (live)
//     decim         : decimation ratio minus one, latched at arm
//     pretrig       : pre-trigger sample count, latched at arm
//     auto_rearm    : restart a new capture after each completed one
//     arm           : single-cycle start / abort-and-restart
//     force_trig    : single-cycle software trigger
//     ext_trig      : external trigger level, rising edge triggers
//     mem           : RAM write port (master modport)
//     state         : 0 IDLE, 1 FILL, 2 ARMED, 3 POST, 4 DONE
//     done          : capture complete level, cleared by arm
//     done_stb      : one-cycle pulse per completed capture
//     trig_addr     : RAM address of the trigger sample
//     start_addr    : RAM address of the oldest sample of the capture
//     capture_count : completed captures, wraps at 2^16
// ---------------------------------------------------------------------------
module adc_capture_ctl #(
    parameter int NCH = 8,
    parameter int DW  = 16,
    parameter int AW  = 14,
    parameter int CW  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NCH*DW-1:0]     adc_data,
    input  logic                  adc_valid,
    input  logic [NCH-1:0]        chan_mask,
    input  logic [CW-1:0]         decim,
    input  logic [AW-1:0]         pretrig,
    input  logic                  auto_rearm,
    input  logic                  arm,
    input  logic                  force_trig,
    input  logic                  ext_trig,
    adc_capture_ctl_if.master     mem,
    output logic [2:0]            state,
    output logic                  done,
    output logic                  done_stb,
    output logic [AW-1:0]         trig_addr,
    output logic [AW-1:0]         start_addr,
    output logic [15:0]           capture_count
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FILL  = 3'd1,
        ST_ARMED = 3'd2,
        ST_POST  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Zero the channels whose mask bit is clear.
    function automatic logic [NCH*DW-1:0] mask_data(
        input logic [NCH*DW-1:0] data,
        input logic [NCH-1:0]    mask
    );
        logic [NCH*DW-1:0] res;
        res = '0;
        for (int k = 0; k < NCH; k++) begin
            res[k*DW +: DW] = mask[k] ? data[k*DW +: DW] : '0;
        end
        return res;
    endfunction

    // -----------------------------------------------------------------------
    // State and register declarations
    // -----------------------------------------------------------------------
    state_t              state_q,        state_d;
    logic [CW-1:0]       dcnt_q,         dcnt_d;
    logic [CW-1:0]       decim_r_q,      decim_r_d;
    logic [AW-1:0]       pretrig_r_q,    pretrig_r_d;
    logic [AW-1:0]       wptr_q,         wptr_d;
    logic [AW-1:0]       fill_cnt_q,     fill_cnt_d;
    logic [AW:0]         post_cnt_q,     post_cnt_d;
    logic                trig_pend_q,    trig_pend_d;
    logic                ext_trig_d_q,   ext_trig_d_d;
    logic                done_q,         done_d;
    logic                done_stb_q,     done_stb_d;
    logic [AW-1:0]       trig_addr_q,    trig_addr_d;
    logic [AW-1:0]       start_addr_q,   start_addr_d;
    logic [15:0]         capture_count_q, capture_count_d;
    logic                mem_we_q,       mem_we_d;
    logic [AW-1:0]       mem_addr_q,     mem_addr_d;
    logic [NCH*DW-1:0]   mem_wdata_q,    mem_wdata_d;

    logic                strobe;
    logic                trig_now;
    logic                in_write_state;
    logic [AW-1:0]       fill_nxt;
    logic [AW:0]         post_nxt;
    logic [AW:0]         post_len;

    assign strobe   = adc_valid && (dcnt_q == '0);
    // Edge detector runs in every state; only ARMED acts on it.
    assign trig_now = force_trig || (ext_trig && !ext_trig_d_q);

    assign in_write_state = (state_q == ST_FILL) || (state_q == ST_ARMED) ||
                            (state_q == ST_POST);

    assign fill_nxt = fill_cnt_q + AW'(1);
    assign post_nxt = post_cnt_q + (AW+1)'(1);
    // Post-trigger length includes the trigger sample itself.
    assign post_len = {1'b1, {AW{1'b0}}} - {1'b0, pretrig_r_q};

    // -----------------------------------------------------------------------
    // Next-state / output logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d         = state_q;
        dcnt_d          = dcnt_q;
        decim_r_d       = decim_r_q;
        pretrig_r_d     = pretrig_r_q;
        wptr_d          = wptr_q;
        fill_cnt_d      = fill_cnt_q;
        post_cnt_d      = post_cnt_q;
        trig_pend_d     = trig_pend_q;
        ext_trig_d_d    = ext_trig;
        done_d          = done_q;
        done_stb_d      = 1'b0;
        trig_addr_d     = trig_addr_q;
        start_addr_d    = start_addr_q;
        capture_count_d = capture_count_q;
        mem_we_d        = 1'b0;
        mem_addr_d      = mem_addr_q;
        mem_wdata_d     = mem_wdata_q;

        if (adc_valid) begin
            dcnt_d = (dcnt_q == decim_r_q) ? '0 : dcnt_q + CW'(1);
        end

        if (arm) begin
            // arm overrides everything in its cycle: no write, trigger dropped.
            decim_r_d   = decim;
            pretrig_r_d = pretrig;
            done_d      = 1'b0;
            wptr_d      = '0;
            dcnt_d      = '0;
            fill_cnt_d  = '0;
            post_cnt_d  = '0;
            trig_pend_d = 1'b0;
            state_d     = (pretrig == '0) ? ST_ARMED : ST_FILL;
        end else begin
            if (strobe && in_write_state) begin
                mem_we_d    = 1'b1;
                mem_addr_d  = wptr_q;
                mem_wdata_d = mask_data(adc_data, chan_mask);
                wptr_d      = wptr_q + AW'(1);
            end

            unique case (state_q)
                ST_FILL: begin
                    if (strobe) begin
                        fill_cnt_d = fill_nxt;
                        if (fill_nxt == pretrig_r_q) begin
                            state_d = ST_ARMED;
                        end
                    end
                end

                ST_ARMED: begin
                    if (strobe && (trig_pend_q || trig_now)) begin
                        trig_addr_d  = wptr_q;
                        start_addr_d = wptr_q - pretrig_r_q;
                        trig_pend_d  = 1'b0;
                        post_cnt_d   = (AW+1)'(1);
                        if (post_len == (AW+1)'(1)) begin
                            // Maximum pretrig: trigger sample is the last one.
                            state_d         = ST_DONE;
                            done_d          = 1'b1;
                            done_stb_d      = 1'b1;
                            capture_count_d = capture_count_q + 16'd1;
                        end else begin
                            state_d = ST_POST;
                        end
                    end else if (trig_now) begin
                        trig_pend_d = 1'b1;
                    end
                end

                ST_POST: begin
                    if (strobe) begin
                        post_cnt_d = post_nxt;
                        if (post_nxt == post_len) begin
                            state_d         = ST_DONE;
                            done_d          = 1'b1;
                            done_stb_d      = 1'b1;
                            capture_count_d = capture_count_q + 16'd1;
                        end
                    end
                end

                ST_DONE: begin
                    if (auto_rearm) begin
                        // Restart with the latched settings; done stays set.
                        wptr_d      = '0;
                        dcnt_d      = '0;
                        fill_cnt_d  = '0;
                        post_cnt_d  = '0;
                        trig_pend_d = 1'b0;
                        state_d     = (pretrig_r_q == '0) ? ST_ARMED : ST_FILL;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end

                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Register stage
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= ST_IDLE;
            dcnt_q          <= '0;
            decim_r_q       <= '0;
            pretrig_r_q     <= '0;
            wptr_q          <= '0;
            fill_cnt_q      <= '0;
            post_cnt_q      <= '0;
            trig_pend_q     <= 1'b0;
            ext_trig_d_q    <= 1'b0;
            done_q          <= 1'b0;
            done_stb_q      <= 1'b0;
            trig_addr_q     <= '0;
            start_addr_q    <= '0;
            capture_count_q <= '0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
        end else begin
            state_q         <= state_d;
            dcnt_q          <= dcnt_d;
            decim_r_q       <= decim_r_d;
            pretrig_r_q     <= pretrig_r_d;
            wptr_q          <= wptr_d;
            fill_cnt_q      <= fill_cnt_d;
            post_cnt_q      <= post_cnt_d;
            trig_pend_q     <= trig_pend_d;
            ext_trig_d_q    <= ext_trig_d_d;
            done_q          <= done_d;
            done_stb_q      <= done_stb_d;
            trig_addr_q     <= trig_addr_d;
            start_addr_q    <= start_addr_d;
            capture_count_q <= capture_count_d;
            mem_we_q        <= mem_we_d;
            mem_addr_q      <= mem_addr_d;
            mem_wdata_q     <= mem_wdata_d;
        end
    end

    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;

    assign state         = state_q;
    assign done          = done_q;
    assign done_stb      = done_stb_q;
    assign trig_addr     = trig_addr_q;
    assign start_addr    = start_addr_q;
    assign capture_count = capture_count_q;

endmodule

// File: tb/tb_adc_capture_ctl.sv
// ---------------------------------------------------------------------------
// tb_adc_capture_ctl
//   Directed bench for adc_capture_ctl with a 16-deep capture RAM (AW=4).
// ---------------------------------------------------------------------------
module tb_adc_capture_ctl;
    localparam int NCH = 8;
    localparam int DW  = 16;
    localparam int AW  = 4;
    localparam int CW  = 10;

    logic                clk;
    logic                rst_n;
    logic [NCH*DW-1:0]   adc_data;
    logic                adc_valid;
    logic [NCH-1:0]      chan_mask;
    logic [CW-1:0]       decim;
    logic [AW-1:0]       pretrig;
    logic                auto_rearm;
    logic                arm;
    logic                force_trig;
    logic                ext_trig;
    logic [2:0]          state;
    logic                done;
    logic                done_stb;
    logic [AW-1:0]       trig_addr;
    logic [AW-1:0]       start_addr;
    logic [15:0]         capture_count;

    int passed = 0;
    int total  = 0;

    adc_capture_ctl_if #(.AW(AW), .WW(NCH*DW)) mem_if ();

    adc_capture_ctl #(.NCH(NCH), .DW(DW), .AW(AW), .CW(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .adc_data      (adc_data),
        .adc_valid     (adc_valid),
        .chan_mask     (chan_mask),
        .decim         (decim),
        .pretrig       (pretrig),
        .auto_rearm    (auto_rearm),
        .arm           (arm),
        .force_trig    (force_trig),
        .ext_trig      (ext_trig),
        .mem           (mem_if),
        .state         (state),
        .done          (done),
        .done_stb      (done_stb),
        .trig_addr     (trig_addr),
        .start_addr    (start_addr),
        .capture_count (capture_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        adc_data   = '0;
        adc_valid  = 1'b0;
        chan_mask  = '0;
        decim      = '0;
        pretrig    = '0;
        auto_rearm = 1'b0;
        arm        = 1'b0;
        force_trig = 1'b0;
        ext_trig   = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) tick();
        chk("rst_state", state, 0);
        chk("rst_mem_we", mem_if.mem_we, 0);
        chk("rst_done", done, 0);
        chk("rst_count", capture_count, 0);
        chk("rst_trig_addr", trig_addr, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- full capture, pretrig=4, decim=0 ----------------
        chan_mask = 8'hFF;
        decim     = 0;
        pretrig   = 4;
        adc_valid = 1'b1;
        adc_data  = '0;
        adc_data[15:0] = 16'hFFFF;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t1_arm_state", state, 1);
        chk("t1_arm_no_we", mem_if.mem_we, 0);
        for (int n = 1; n <= 22; n++) begin
            adc_data = '0;
            adc_data[15:0] = 16'(n - 1);
            force_trig = (n == 11);
            tick();
            force_trig = 1'b0;
            chk("t1_we", mem_if.mem_we, 1);
            chk("t1_addr", mem_if.mem_addr, (n - 1) % 16);
            chk("t1_data", mem_if.mem_wdata, n - 1);
            chk("t1_state", state, (n < 4) ? 1 : (n <= 10) ? 2 : (n <= 21) ? 3 : 4);
            chk("t1_done_stb", done_stb, (n == 22) ? 1 : 0);
        end
        chk("t1_trig_addr", trig_addr, 10);
        chk("t1_start_addr", start_addr, 6);
        chk("t1_done", done, 1);
        chk("t1_count", capture_count, 1);
        tick();
        chk("t1_after_we", mem_if.mem_we, 0);
        chk("t1_after_state", state, 0);
        chk("t1_after_done", done, 1);
        chk("t1_after_stb", done_stb, 0);

        // ---------------- decimation, decim=2 ----------------
        decim   = 2;
        pretrig = 4;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            adc_data = '0;
            adc_data[15:0] = 16'(k + 100);
            tick();
            chk("t2_we", mem_if.mem_we, (k % 3 == 1) ? 1 : 0);
            if (k % 3 == 1) begin
                chk("t2_data", mem_if.mem_wdata, k + 100);
                chk("t2_addr", mem_if.mem_addr, (k - 1) / 3);
            end
        end

        // ---------------- ext trigger edges, pretrig=2, decim=2 ----------------
        decim   = 2;
        pretrig = 2;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        for (int k = 1; k <= 13; k++) begin
            ext_trig = (k >= 2 && k != 11);
            tick();
            if (k == 4)  chk("t3_armed_after_fill", state, 2);
            if (k == 10) chk("t3_held_no_trig", state, 2);
            if (k == 12) begin
                chk("t3_pend_state", state, 2);
                chk("t3_pend_no_we", mem_if.mem_we, 0);
            end
            if (k == 13) begin
                chk("t3_post_state", state, 3);
                chk("t3_trig_addr", trig_addr, 4);
                chk("t3_start_addr", start_addr, 2);
                chk("t3_trig_we", mem_if.mem_we, 1);
                chk("t3_trig_waddr", mem_if.mem_addr, 4);
            end
        end
        ext_trig = 1'b0;
        tick();
        tick();

        // ---------------- abort: arm in POST on a strobe cycle ----------------
        decim   = 0;
        pretrig = 2;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t6_abort_state", state, 1);
        chk("t6_abort_no_we", mem_if.mem_we, 0);
        chk("t6_abort_done", done, 0);
        tick();
        chk("t6_restart_we", mem_if.mem_we, 1);
        chk("t6_restart_addr", mem_if.mem_addr, 0);
        tick();
        chk("t6_fill_addr1", mem_if.mem_addr, 1);
        chk("t6_armed", state, 2);
        force_trig = 1'b1;
        tick();
        force_trig = 1'b0;
        chk("t6_post", state, 3);
        chk("t6_trig_addr", trig_addr, 2);

        // ---------------- async reset mid-POST ----------------
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_state", state, 0);
        chk("t6_rst_we", mem_if.mem_we, 0);
        chk("t6_rst_addr", mem_if.mem_addr, 0);
        chk("t6_rst_wdata", mem_if.mem_wdata, 0);
        chk("t6_rst_trig_addr", trig_addr, 0);
        chk("t6_rst_start_addr", start_addr, 0);
        chk("t6_rst_count", capture_count, 0);
        chk("t6_rst_done", done, 0);
        tick();
        chk("t6_rst_hold_we", mem_if.mem_we, 0);
        rst_n = 1'b1;
        tick();

        // ---------------- mask, pretrig=0 ----------------
        chan_mask = 8'b00000101;
        adc_data  = {NCH{16'hA5A5}};
        decim     = 0;
        pretrig   = 0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t4_straight_armed", state, 2);
        chk("t4_arm_no_we", mem_if.mem_we, 0);
        tick();
        chk("t4_we", mem_if.mem_we, 1);
        chk("t4_addr", mem_if.mem_addr, 0);
        chk("t4_masked", mem_if.mem_wdata, 128'h0000_A5A5_0000_A5A5);
        chan_mask = 8'hFF;
        tick();
        chk("t4_live_mask", mem_if.mem_wdata, {NCH{16'hA5A5}});
        chk("t4_addr1", mem_if.mem_addr, 1);

        // ---------------- auto-rearm, three captures ----------------
        auto_rearm = 1'b1;
        pretrig    = 0;
        decim      = 0;
        arm = 1'b1;
        tick();
        arm = 1'b0;
        chk("t5_armed", state, 2);
        chk("t5_done_clr", done, 0);
        for (int c = 1; c <= 3; c++) begin
            force_trig = 1'b1;
            tick();
            force_trig = 1'b0;
            chk("t5_post", state, 3);
            chk("t5_trig_addr", trig_addr, 0);
            chk("t5_waddr0", mem_if.mem_addr, 0);
            repeat (15) tick();
            chk("t5_done_state", state, 4);
            chk("t5_done_stb", done_stb, 1);
            chk("t5_count", capture_count, c);
            chk("t5_done", done, 1);
            tick();
            chk("t5_rearmed", state, 2);
            chk("t5_stb_clr", done_stb, 0);
            chk("t5_done_held", done, 1);
            chk("t5_no_we", mem_if.mem_we, 0);
        end
        auto_rearm = 1'b0;
        adc_valid  = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
